overflow_monitor: RTL and testbench
===================================

# overflow_monitor

Registered, parametrised arithmetic status unit for the datapath ALU stage. Computes WIDTH-bit add/sub with N/Z/C/V flags, decides overflow per signed/unsigned mode, and keeps a sticky overflow bit, a saturating overflow counter and a req/ack exception handshake toward the control unit. Sits between the ALU operand registers and the control/exception logic. It generalises the single-bit XOR overflow check to full-width, mode-aware detection with state.

## Interface

Parameters:
- WIDTH, 32, operand/result width (>= 2)
- COUNT_W, 8, overflow counter width (>= 1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- valid  in  1  operands valid this cycle
- op_sub  in  1  0 = a+b, 1 = a-b
- is_signed  in  1  1 = two's-complement overflow rule, 0 = unsigned rule
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- clear_sticky  in  1  clears sticky_ovf, exc_miss and ovf_count
- exc_ack  in  1  control unit accepts the exception request
- result  out  WIDTH  registered sum/difference
- out_valid  out  1  one-cycle pulse: result/flags updated
- flag_n, flag_z, flag_c, flag_v  out  1 each  registered flags
- ovf_event  out  1  overflow of the operation reported by out_valid
- sticky_ovf  out  1  set by any overflow event, held until clear_sticky
- exc_miss  out  1  sticky: overflow occurred while a request was pending
- ovf_count  out  COUNT_W  saturating overflow count
- exc_req  out  1  exception request

## Operation

- Adder: sum = a + (op_sub ? ~b : b) + op_sub, WIDTH+1 bits; result = sum[WIDTH-1:0].
- flag_c = sum[WIDTH] (for subtraction, 1 = no borrow). flag_n = result MSB. flag_z = (result == 0).
- flag_v = carry into MSB XOR carry out of MSB, independent of is_signed.
- Overflow decision ovf: is_signed ? flag_v : (op_sub ? ~flag_c : flag_c).
- When valid = 0, result, flags and ovf_event hold; out_valid = 0.
- sticky_ovf set on each overflow event; ovf_count increments, saturating at 2^COUNT_W-1.
- clear_sticky clears sticky_ovf, exc_miss and ovf_count. On the same edge as an overflow event, the event wins: sticky_ovf = 1, ovf_count = 1, exc_miss unchanged from its cleared value unless the event itself is missed.
- Exception FSM, states IDLE and REQ; exc_req = (state == REQ).
  - IDLE: overflow event -> REQ.
  - REQ: exc_ack without event -> IDLE. Event without exc_ack -> stay REQ, set exc_miss. exc_ack with event -> stay REQ (old request consumed, new one raised; exc_miss not set).
  - exc_ack in IDLE ignored.

## Timing

- Latency 1: inputs sampled at edge t with valid = 1; result, flags, ovf_event, out_valid, sticky_ovf, ovf_count, FSM state all update at that edge, visible in cycle t+1.
- exc_req rises in cycle t+1 after an overflow sampled at edge t; falls the cycle after the edge sampling exc_ack.
- Back-to-back valid every cycle supported; no stall.
- Reset (any state, including REQ): all outputs 0, state IDLE, next cycle. Reset overrides valid, clear_sticky and exc_ack.

## Configuration

- OVF_COUNT_EN defined: counter registers present, ovf_count behaves as above.
- Not defined: no counter logic; ovf_count port remains and is tied to 0; all other behaviour identical.

## Test plan

(WIDTH = 8, OVF_COUNT_EN defined unless noted.)
- Signed add 0x7F+0x01 -> result 0x80, N=1 Z=0 C=0 V=1, ovf_event=1, sticky_ovf=1, ovf_count=1, exc_req=1 in the following cycle.
- Unsigned add 0xFF+0x01 -> result 0x00, Z=1 C=1 V=0, ovf_event=1. Same operands with is_signed=1 -> ovf_event=0.
- Signed sub 0x80-0x01 -> 0x7F, C=1 V=1, ovf_event=1. Unsigned sub 0x00-0x01 -> 0xFF, C=0 N=1, ovf_event=1.
- Handshake: overflow, then hold exc_ack=0 for 3 cycles -> exc_req stays 1. Second overflow during REQ -> exc_miss=1, ovf_count=2. Pulse exc_ack -> exc_req=0 next cycle. exc_ack coincident with an overflow -> exc_req stays 1.
- COUNT_W = 2: 5 overflows -> ovf_count=3. clear_sticky alone -> 0. clear_sticky on the same edge as an overflow -> sticky_ovf=1, ovf_count=1. Macro undefined -> ovf_count=0 throughout.
- Assert reset while in REQ with sticky_ovf=1 -> next cycle all outputs 0; exc_ack afterwards has no effect.

Source files
------------

// File: rtl/overflow_monitor.sv
// overflow_monitor: registered add/sub with N/Z/C/V flags, mode-aware overflow, sticky/count and req/ack exception (counter only when OVF_COUNT_EN is defined)
module overflow_monitor #(
   parameter int WIDTH   = 32,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               valid,
   input  logic               op_sub,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               clear_sticky,
   input  logic               exc_ack,
   output logic [WIDTH-1:0]   result,
   output logic               out_valid,
   output logic               flag_n,
   output logic               flag_z,
   output logic               flag_c,
   output logic               flag_v,
   output logic               ovf_event,
   output logic               sticky_ovf,
   output logic               exc_miss,
   output logic [COUNT_W-1:0] ovf_count,
   output logic               exc_req
);
   typedef enum logic {IDLE, REQ} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] bx;
   logic [WIDTH:0] sum;
   logic c, v, ovf, ev, miss;
   // adder, flags, overflow decision and next exception state
   always_comb begin
      bx = op_sub ? ~b : b;
      sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, op_sub};
      c = sum[WIDTH];
      v = (a[WIDTH-1] ^ bx[WIDTH-1] ^ sum[WIDTH-1]) ^ c;
      ovf = is_signed ? v : (op_sub ? ~c : c);
      ev = valid & ovf;
      miss = ev & (state == REQ) & ~exc_ack;
      state_nx = state;
      state_nx = ev ? REQ : (exc_ack ? IDLE : state);
   end
   // result and flags update only on valid operations
   always_ff @(posedge clk) begin
      if (reset) begin
         result <= '0;
         out_valid <= 1'b0;
         flag_n <= 1'b0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
         ovf_event <= 1'b0;
      end else begin
         out_valid <= valid;
         if (valid) begin
            result <= sum[WIDTH-1:0];
            flag_n <= sum[WIDTH-1];
            flag_z <= ~|sum[WIDTH-1:0];
            flag_c <= c;
            flag_v <= v;
            ovf_event <= ovf;
         end
      end
   end
   // sticky bits and exception state; a new event beats clear_sticky
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sticky_ovf <= 1'b0;
         exc_miss <= 1'b0;
      end else begin
         state <= state_nx;
         sticky_ovf <= ev ? 1'b1 : (clear_sticky ? 1'b0 : sticky_ovf);
         exc_miss <= miss ? 1'b1 : (clear_sticky ? 1'b0 : exc_miss);
      end
   end
   assign exc_req = (state == REQ);
`ifdef OVF_COUNT_EN
   logic [COUNT_W-1:0] cnt;
   // saturating overflow counter; an event on a clearing edge restarts at 1
   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else if (ev) cnt <= clear_sticky ? COUNT_W'(1) : (&cnt ? cnt : cnt + COUNT_W'(1));
      else if (clear_sticky) cnt <= '0;
   end
   assign ovf_count = cnt;
`else
   assign ovf_count = '0;
`endif
endmodule

// File: tb/tb_overflow_monitor.sv
// tb_overflow_monitor: directed and table-driven check of overflow_monitor (WIDTH=8, COUNT_W=2) against an arithmetic reference model
module tb_overflow_monitor;
`ifdef OVF_COUNT_EN
   localparam bit CEN = 1'b1;
`else
   localparam bit CEN = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset, valid, op_sub, is_signed, clear_sticky, exc_ack;
   logic [7:0] a, b, result;
   logic out_valid, flag_n, flag_z, flag_c, flag_v, ovf_event, sticky_ovf, exc_miss, exc_req;
   logic [1:0] ovf_count;
   int checks = 0, errors = 0;
   logic [7:0] m_res;
   bit m_ov, m_n, m_z, m_c, m_v, m_ev, m_sticky, m_miss, m_pend;
   int m_cnt;

   overflow_monitor #(.WIDTH(8), .COUNT_W(2)) dut (
      .clk(clk), .reset(reset), .valid(valid), .op_sub(op_sub), .is_signed(is_signed),
      .a(a), .b(b), .clear_sticky(clear_sticky), .exc_ack(exc_ack), .result(result),
      .out_valid(out_valid), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
      .ovf_event(ovf_event), .sticky_ovf(sticky_ovf), .exc_miss(exc_miss),
      .ovf_count(ovf_count), .exc_req(exc_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // reference model: integer arithmetic on the sampled inputs
   task automatic model_update();
      int ua, ub, sa, sb, sr;
      bit ev, ovf;
      ev = 1'b0;
      if (reset) begin
         m_res = 0; m_ov = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_ev = 0;
         m_sticky = 0; m_miss = 0; m_pend = 0; m_cnt = 0;
         return;
      end
      m_ov = valid;
      if (valid) begin
         ua = int'(a); ub = int'(b);
         sa = ua >= 128 ? ua - 256 : ua;
         sb = ub >= 128 ? ub - 256 : ub;
         sr = op_sub ? sa - sb : sa + sb;
         m_res = 8'(op_sub ? ua - ub : ua + ub);
         m_c = op_sub ? (ua >= ub) : (ua + ub > 255);
         m_v = (sr > 127) || (sr < -128);
         m_n = m_res[7];
         m_z = (m_res == 0);
         ovf = is_signed ? m_v : (op_sub ? !m_c : m_c);
         m_ev = ovf;
         ev = ovf;
      end
      if (ev && m_pend && !exc_ack) m_miss = 1;
      else if (clear_sticky) m_miss = 0;
      if (ev) m_sticky = 1;
      else if (clear_sticky) m_sticky = 0;
      if (!CEN) m_cnt = 0;
      else if (ev) m_cnt = clear_sticky ? 1 : (m_cnt < 3 ? m_cnt + 1 : 3);
      else if (clear_sticky) m_cnt = 0;
      if (ev) m_pend = 1;
      else if (exc_ack) m_pend = 0;
   endtask

   task automatic compare();
      chk("result", result, m_res);
      chk("out_valid", out_valid, m_ov);
      chk("flag_n", flag_n, m_n);
      chk("flag_z", flag_z, m_z);
      chk("flag_c", flag_c, m_c);
      chk("flag_v", flag_v, m_v);
      chk("ovf_event", ovf_event, m_ev);
      chk("sticky_ovf", sticky_ovf, m_sticky);
      chk("exc_miss", exc_miss, m_miss);
      chk("ovf_count", ovf_count, m_cnt);
      chk("exc_req", exc_req, m_pend);
   endtask

   task automatic step(input bit rs, input bit v, input bit sub, input bit sg,
                       input logic [7:0] aa, input logic [7:0] bb, input bit clr, input bit ack);
      reset = rs; valid = v; op_sub = sub; is_signed = sg; a = aa; b = bb;
      clear_sticky = clr; exc_ack = ack;
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
   endtask

   task automatic idle(input bit clr, input bit ack);
      step(0, 0, 0, 0, 8'h00, 8'h00, clr, ack);
   endtask

   task automatic sovf();
      step(0, 1, 0, 1, 8'h7F, 8'h01, 0, 0);
   endtask

   initial begin
      step(1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
      step(1, 1, 0, 1, 8'h7F, 8'h01, 1, 1);
      chk("rst_result", result, 8'h00);
      chk("rst_outs", {out_valid, ovf_event, sticky_ovf, exc_miss, exc_req}, 5'b0);
      chk("rst_cnt", ovf_count, 2'd0);
      sovf();
      chk("sadd_res", result, 8'h80);
      chk("sadd_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b1001);
      chk("sadd_ev", {out_valid, ovf_event, sticky_ovf, exc_req}, 4'b1111);
      chk("sadd_cnt", ovf_count, CEN ? 2'd1 : 2'd0);
      idle(0, 0);
      chk("hold_res", {out_valid, result, ovf_event}, {1'b0, 8'h80, 1'b1});
      idle(0, 1);
      chk("ack_drop", exc_req, 1'b0);
      idle(1, 0);
      chk("clr_sticky", sticky_ovf, 1'b0);
      step(0, 1, 0, 0, 8'hFF, 8'h01, 0, 0);
      chk("uadd_res", result, 8'h00);
      chk("uadd_zcv", {flag_z, flag_c, flag_v, ovf_event}, 4'b1101);
      step(0, 1, 0, 1, 8'hFF, 8'h01, 0, 1);
      chk("sadd_noovf", {flag_c, ovf_event, exc_req}, 3'b100);
      step(0, 1, 1, 1, 8'h80, 8'h01, 0, 0);
      chk("ssub_res", result, 8'h7F);
      chk("ssub_cv", {flag_c, flag_v, ovf_event}, 3'b111);
      step(0, 1, 1, 0, 8'h00, 8'h01, 0, 1);
      chk("usub_res", result, 8'hFF);
      chk("usub_cn", {flag_c, flag_n, ovf_event, exc_req, exc_miss}, 5'b01110);
      idle(0, 1);
      idle(1, 0);
      sovf();
      for (int i = 0; i < 3; i++) begin
         idle(0, 0);
         chk("req_hold", exc_req, 1'b1);
      end
      sovf();
      chk("miss_set", {exc_miss, exc_req}, 2'b11);
      chk("miss_cnt", ovf_count, CEN ? 2'd2 : 2'd0);
      idle(0, 1);
      chk("ack_pulse", {exc_req, exc_miss}, 2'b01);
      sovf();
      step(0, 1, 0, 1, 8'h7F, 8'h01, 0, 1);
      chk("ack_ev", exc_req, 1'b1);
      idle(1, 1);
      for (int i = 0; i < 5; i++) sovf();
      chk("sat_cnt", ovf_count, CEN ? 2'd3 : 2'd0);
      idle(1, 0);
      chk("clr_cnt", {sticky_ovf, exc_miss, ovf_count}, 4'b0000);
      step(0, 1, 0, 1, 8'h7F, 8'h01, 1, 0);
      chk("clr_ev", {sticky_ovf, ovf_count}, {1'b1, CEN ? 2'd1 : 2'd0});
      sovf();
      step(1, 1, 0, 1, 8'h7F, 8'h01, 1, 1);
      chk("rst_req", {result, out_valid, flag_n, flag_z, flag_c, flag_v, ovf_event,
                      sticky_ovf, exc_miss, ovf_count, exc_req}, 20'd0);
      idle(0, 1);
      chk("post_rst_ack", {exc_req, sticky_ovf}, 2'b00);
      step(0, 1, 0, 0, 8'h80, 8'h80, 0, 0);
      step(0, 1, 1, 1, 8'h7F, 8'hFF, 0, 0);
      step(0, 1, 1, 0, 8'h05, 8'h05, 0, 1);
      step(0, 1, 0, 1, 8'h80, 8'hFF, 0, 0);
      step(0, 1, 0, 0, 8'h12, 8'h34, 0, 1);
      for (int i = 0; i < 40; i++)
         step(0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
              $urandom_range(0, 7) == 0, 1'($urandom));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
